conv_chan_accum: RTL and testbench

- Parametrised cross-channel accumulator for the CNN convolution layers. It succeeds the fixed 3-in/3-out partial-sum FIFO-and-adder stage.
- Upstream, a single-channel convolution engine emits one frame of OUT_CH partial sums per input channel. This block sums the IN_CH passes per pixel in an internal RAM, adds per-output-channel bias, applies ReLU and streams one result frame.
- Any IN_CH, OUT_CH, frame size and width; no external FIFO IP.

---
 rtl/conv_chan_accum_if.sv | 33 +++
 rtl/conv_chan_accum.sv | 102 ++++++++++
 tb/tb_conv_chan_accum.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_chan_accum_if.sv
// conv_chan_accum_if: partial-sum input / accumulated-result output bundle
// Ports (signals):
//   predict_end    - synchronous frame abort/clear (master -> slave)
//   psum_in        - OUT_CH packed signed partial sums, channel k at [k*IN_W +: IN_W]
//   psum_valid     - one pixel per beat, raster order
//   data_out       - OUT_CH packed ReLU'd results, channel k at [k*ACC_W +: ACC_W]
//   data_out_valid - result qualifier
//   pass_idx       - current input-channel pass
//   frame_done     - pulse with the last result of a frame
//   acc_ovf        - sticky saturation flag (saturating build only)
interface conv_chan_accum_if #(
    parameter int OUT_CH = 3,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 32,
    parameter int PW     = 2
);
    logic                      predict_end;
    logic [OUT_CH*IN_W-1:0]    psum_in;
    logic                      psum_valid;
    logic [OUT_CH*ACC_W-1:0]   data_out;
    logic                      data_out_valid;
    logic [PW-1:0]             pass_idx;
    logic                      frame_done;
    logic                      acc_ovf;
    modport master (
        output predict_end, psum_in, psum_valid,
        input  data_out, data_out_valid, pass_idx, frame_done, acc_ovf
    );
    modport slave (
        input  predict_end, psum_in, psum_valid,
        output data_out, data_out_valid, pass_idx, frame_done, acc_ovf
    );
endinterface

// File: rtl/conv_chan_accum.sv
// conv_chan_accum: cross-channel partial-sum accumulator with bias and ReLU
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - conv_chan_accum_if.slave (psum input beats, result stream, status)
// Build option: define CONV_CHAN_ACCUM_SAT_EN to saturate every add and
// enable the sticky acc_ovf flag; otherwise adds wrap and acc_ovf stays 0.
module conv_chan_accum #(
    parameter int IN_CH   = 3,
    parameter int OUT_CH  = 3,
    parameter int PIX_NUM = 121,
    parameter int IN_W    = 32,
    parameter int ACC_W   = 32,
    parameter logic [OUT_CH*ACC_W-1:0] BIAS = '0
) (
    input logic clk,
    input logic rst_n,
    conv_chan_accum_if.slave bus
);
`ifdef CONV_CHAN_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int PW  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int PCW = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam logic [PW-1:0]  LAST_PASS = PW'(IN_CH - 1);
    localparam logic [PCW-1:0] LAST_PIX  = PCW'(PIX_NUM - 1);

    // Returns {clamped, sum}; clamping only happens in the saturating build.
    function automatic logic [ACC_W:0] add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] w;
        w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (SAT && (w[ACC_W] != w[ACC_W-1]))
            return {1'b1, w[ACC_W], {(ACC_W-1){~w[ACC_W]}}};
        return {1'b0, w[ACC_W-1:0]};
    endfunction

    logic [OUT_CH*ACC_W-1:0] mem [PIX_NUM];
    logic [OUT_CH*ACC_W-1:0] rd, nxt, relu, data_out;
    logic [OUT_CH-1:0]       clamp;
    logic [PCW-1:0]          pix_cnt;
    logic [PW-1:0]           pass_idx;
    logic                    data_out_valid, frame_done, acc_ovf;
    logic                    beat, first, last, pix_last;

    // Clear wins over a coincident beat.
    assign beat     = bus.psum_valid & ~bus.predict_end;
    assign first    = (pass_idx == '0);
    assign last     = (pass_idx == LAST_PASS);
    assign pix_last = (pix_cnt == LAST_PIX);
    assign rd       = mem[pix_cnt];

    for (genvar k = 0; k < OUT_CH; k++) begin : g_ch
        logic signed [IN_W-1:0] e;
        logic [ACC_W-1:0]       s, m;
        logic [ACC_W:0]         a1, a2;
        assign e = bus.psum_in[k*IN_W +: IN_W];
        assign s = ACC_W'(e);
        // Pass 0 ignores stale RAM contents, so no clear cycle is needed.
        assign m  = first ? '0 : rd[k*ACC_W +: ACC_W];
        assign a1 = add(m, s);
        assign a2 = add(a1[ACC_W-1:0], BIAS[k*ACC_W +: ACC_W]);
        assign nxt[k*ACC_W +: ACC_W]  = a1[ACC_W-1:0];
        assign relu[k*ACC_W +: ACC_W] = a2[ACC_W-1] ? '0 : a2[ACC_W-1:0];
        assign clamp[k] = a1[ACC_W] | (last & a2[ACC_W]);
    end

    always_ff @(posedge clk)
        if (beat) mem[pix_cnt] <= nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pix_cnt        <= '0;
            pass_idx       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            acc_ovf        <= 1'b0;
        end else if (bus.predict_end) begin
            pix_cnt        <= '0;
            pass_idx       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            acc_ovf        <= 1'b0;
        end else begin
            data_out_valid <= beat & last;
            frame_done     <= beat & last & pix_last;
            if (beat & last) data_out <= relu;
            if (beat) begin
                pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
                if (pix_last) pass_idx <= last ? '0 : pass_idx + 1'b1;
            end
            if (beat & |clamp) acc_ovf <= 1'b1;
        end

    assign bus.data_out       = data_out;
    assign bus.data_out_valid = data_out_valid;
    assign bus.pass_idx       = pass_idx;
    assign bus.frame_done     = frame_done;
    assign bus.acc_ovf        = acc_ovf;
endmodule

// File: tb/tb_conv_chan_accum.sv
// tb_conv_chan_accum: directed scoreboard bench over four differently configured instances
module tb_conv_chan_accum;
`ifdef CONV_CHAN_ACCUM_SAT_EN
    localparam bit SATB = 1'b1;
`else
    localparam bit SATB = 1'b0;
`endif
    localparam logic [95:0] B0 = {32'(-196608), 32'(-524288), 32'(-131072)};
    localparam logic [95:0] B2 = 96'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_chan_accum_if #(.OUT_CH(3), .IN_W(32), .ACC_W(32), .PW(2)) i0 ();
    conv_chan_accum_if #(.OUT_CH(3), .IN_W(32), .ACC_W(32), .PW(2)) i1 ();
    conv_chan_accum_if #(.OUT_CH(3), .IN_W(32), .ACC_W(32), .PW(1)) i2 ();
    conv_chan_accum_if #(.OUT_CH(3), .IN_W(16), .ACC_W(16), .PW(2)) i3 ();

    conv_chan_accum #(.IN_CH(3), .OUT_CH(3), .PIX_NUM(4), .IN_W(32), .ACC_W(32), .BIAS(B0))
        d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    conv_chan_accum #(.IN_CH(3), .OUT_CH(3), .PIX_NUM(4), .IN_W(32), .ACC_W(32), .BIAS(96'd0))
        d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    conv_chan_accum #(.IN_CH(1), .OUT_CH(3), .PIX_NUM(4), .IN_W(32), .ACC_W(32), .BIAS(B2))
        d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    conv_chan_accum #(.IN_CH(3), .OUT_CH(3), .PIX_NUM(2), .IN_W(16), .ACC_W(16), .BIAS(48'd0))
        d3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

    logic [95:0] pin [4];
    logic        pv [4];
    logic        pe [4];
    logic [95:0] odat [4];
    logic        odv [4];
    logic        ofd [4];
    logic        oovf [4];
    int          opass [4];

    assign i0.psum_in = pin[0];
    assign i0.psum_valid = pv[0];
    assign i0.predict_end = pe[0];
    assign i1.psum_in = pin[1];
    assign i1.psum_valid = pv[1];
    assign i1.predict_end = pe[1];
    assign i2.psum_in = pin[2];
    assign i2.psum_valid = pv[2];
    assign i2.predict_end = pe[2];
    assign i3.psum_in = pin[3][47:0];
    assign i3.psum_valid = pv[3];
    assign i3.predict_end = pe[3];

    assign odat[0] = i0.data_out;
    assign odat[1] = i1.data_out;
    assign odat[2] = i2.data_out;
    assign odat[3] = {48'b0, i3.data_out};
    assign odv[0] = i0.data_out_valid;
    assign odv[1] = i1.data_out_valid;
    assign odv[2] = i2.data_out_valid;
    assign odv[3] = i3.data_out_valid;
    assign ofd[0] = i0.frame_done;
    assign ofd[1] = i1.frame_done;
    assign ofd[2] = i2.frame_done;
    assign ofd[3] = i3.frame_done;
    assign oovf[0] = i0.acc_ovf;
    assign oovf[1] = i1.acc_ovf;
    assign oovf[2] = i2.acc_ovf;
    assign oovf[3] = i3.acc_ovf;
    assign opass[0] = 32'(i0.pass_idx);
    assign opass[1] = 32'(i1.pass_idx);
    assign opass[2] = 32'(i2.pass_idx);
    assign opass[3] = 32'(i3.pass_idx);

    typedef struct {
        logic [95:0] d;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t q [4][$];
    int   ich [4] = '{3, 3, 1, 3};
    int   npix [4] = '{4, 4, 4, 2};
    int   epass [4] = '{0, 0, 0, 0};
    int   epix [4] = '{0, 0, 0, 0};
    logic eovf = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, check every instance, then release inputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                chk($sformatf("d%0d reset valid", d), 96'(odv[d]), 96'd0);
                chk($sformatf("d%0d reset data", d), odat[d], 96'd0);
                chk($sformatf("d%0d reset done", d), 96'(ofd[d]), 96'd0);
                chk($sformatf("d%0d reset pass", d), 96'(opass[d]), 96'd0);
                chk($sformatf("d%0d reset ovf", d), 96'(oovf[d]), 96'd0);
            end else begin
                chk($sformatf("d%0d pass_idx c%0d", d, cyc), 96'(opass[d]), 96'(epass[d]));
                chk($sformatf("d%0d acc_ovf c%0d", d, cyc), 96'(oovf[d]), 96'((d == 3) ? eovf : 1'b0));
                if (odv[d]) begin
                    checks++;
                    assert (q[d].size() > 0) else begin
                        errors++;
                        $error("FAIL d%0d unexpected output c%0d: observed %0h expected none", d, cyc, odat[d]);
                    end
                    if (q[d].size() > 0) begin
                        e = q[d].pop_front();
                        chk($sformatf("d%0d data c%0d", d, cyc), odat[d], e.d);
                        chk($sformatf("d%0d frame_done c%0d", d, cyc), 96'(ofd[d]), 96'(e.fd));
                        chk($sformatf("d%0d latency", d), 96'(cyc), 96'(e.cyc));
                    end
                end else
                    chk($sformatf("d%0d stray frame_done c%0d", d, cyc), 96'(ofd[d]), 96'd0);
            end
            pv[d] = 1'b0;
            pe[d] = 1'b0;
        end
    endtask

    // One psum beat; the expected result is queued only if the model says it is a last-pass beat.
    task automatic beat(input int d, input logic [95:0] v, input logic [95:0] ev);
        tick();
        pin[d] = v;
        pv[d] = 1'b1;
        if (epass[d] == ich[d] - 1)
            q[d].push_back('{ev, epix[d] == npix[d] - 1, cyc + 1});
        epix[d]++;
        if (epix[d] == npix[d]) begin
            epix[d] = 0;
            epass[d] = (epass[d] + 1) % ich[d];
        end
    endtask

    task automatic clear(input int d, input logic with_beat);
        tick();
        pe[d] = 1'b1;
        pv[d] = with_beat;
        pin[d] = {3{32'h1234_5678}};
        epass[d] = 0;
        epix[d] = 0;
        if (d == 3) eovf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [95:0] p3(input int a, input int b, input int c);
        return {c, b, a};
    endfunction

    function automatic logic [95:0] h3(input int a, input int b, input int c);
        return {48'b0, 16'(c), 16'(b), 16'(a)};
    endfunction

    initial begin
        for (int d = 0; d < 4; d++) begin
            pin[d] = '0;
            pv[d] = 1'b0;
            pe[d] = 1'b0;
        end
        repeat (4) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                pv[d] = 1'($urandom_range(0, 1));
                pin[d] = {$urandom, $urandom, $urandom};
            end
        end
        tick();
        rst_n = 1'b1;
        idle(2);

        for (int p = 0; p < 3; p++)
            for (int x = 0; x < 4; x++)
                beat(0, p3(100000, 100000, 100000), p3(168928, 0, 103392));
        idle(2);

        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 3; p++)
                for (int x = 0; x < 4; x++)
                    if (f == 0) beat(1, p3(999, 5, -2), p3(2997, 15, 0));
                    else beat(1, p3(x * 10, -1, x), p3(x * 30, 0, 3 * x));
        idle(2);

        for (int x = 0; x < 4; x++) beat(1, p3(50, 50, 50), '0);
        beat(1, p3(50, 50, 50), '0);
        beat(1, p3(50, 50, 50), '0);
        clear(1, 1'b1);
        idle(1);
        for (int p = 0; p < 3; p++)
            for (int x = 0; x < 4; x++)
                beat(1, p3(7, 0, -7), p3(21, 0, 0));
        idle(2);

        beat(2, p3(-5, 0, 0), p3(0, 0, 0));
        idle(1);
        beat(2, p3(5, 0, 0), p3(8, 0, 0));
        beat(2, p3(1, 2, -1), p3(4, 2, 0));
        idle(1);
        beat(2, p3(-3, 0, 0), p3(0, 0, 0));
        for (int x = 0; x < 4; x++) beat(2, p3(x, 0, 0), p3(x + 3, 0, 0));
        idle(2);

        for (int p = 0; p < 3; p++)
            for (int x = 0; x < 2; x++) begin
                beat(3, h3(20000, 100, -20000), SATB ? h3(32767, 300, 0) : h3(0, 300, 5536));
                if (p == 1 && x == 0) eovf = SATB;
            end
        idle(3);
        clear(3, 1'b0);
        for (int p = 0; p < 3; p++)
            for (int x = 0; x < 2; x++)
                beat(3, h3(1, 1, 1), h3(3, 3, 3));
        idle(3);

        for (int d = 0; d < 4; d++)
            chk($sformatf("d%0d drained", d), 96'(q[d].size()), 96'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
